// File: rtl/inv_cipher_iter_if.sv
// Handshake and data bundle for the iterative AES inverse-cipher engine.
// Ports: ciphertext in (in_valid/in_ready/in_data), round-key lookup (rk_idx/rk_data),
//        plaintext out (out_valid/out_ready/out_data), busy status.
interface inv_cipher_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [0:127] in_data;
    logic [3:0]   rk_idx;
    logic [0:127] rk_data;
    logic         out_valid;
    logic         out_ready;
    logic [0:127] out_data;
    logic         busy;

    // Engine side.
    modport slave (
        input  in_valid, in_data, rk_data, out_ready,
        output in_ready, rk_idx, out_valid, out_data, busy
    );

    // Source / key store / sink side.
    modport master (
        output in_valid, in_data, rk_data, out_ready,
        input  in_ready, rk_idx, out_valid, out_data, busy
    );
endinterface

// File: rtl/inv_cipher_iter.sv
// Iterative AES inverse cipher: one 128-bit block per transaction, NR rounds, SB_LANES S-box bytes per cycle.
// Latency: accept edge + NR*(16/SB_LANES+2) edges to out_valid; one block in flight at a time.
// Backpressure: result held in DONE with out_valid=1 until out_ready; in_ready only in IDLE.
// Ports: clk, rst (async, active-high); bus = inv_cipher_iter_if.slave carrying the input handshake,
//        the combinational round-key lookup (rk_idx -> rk_data), the output handshake and busy.
module inv_cipher_iter #(
    parameter int NR       = 10,
    parameter int SB_LANES = 16
) (
    input  logic              clk,
    input  logic              rst,
    inv_cipher_iter_if.slave  bus
);

    localparam int S  = 16 / SB_LANES;
    localparam int KW = (S > 1) ? $clog2(S) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(S - 1);

    typedef enum logic [2:0] {IDLE, SHIFT, SUB, KEY, DONE} state_t;

    state_t       st_q, st_d;
    logic [0:127] blk_q, blk_d;
    logic [0:127] out_q, out_d;
    logic [3:0]   r_q, r_d;
    logic [KW-1:0] k_q, k_d;
    logic [0:127] t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Undo the S-box affine map, then invert in GF(2^8) as a^254 (0 maps to 0).
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] a;
        logic [7:0] r;
        logic [7:0] base;
        logic [7:0] e;
        a    = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        e    = 8'd254;
        r    = 8'h01;
        base = a;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gmul(r, base);
            base = gmul(base, base);
        end
        return r;
    endfunction

    // Byte 4*c+r is row r, column c; row r rotates right by r.
    function automatic logic [0:127] inv_shift_rows(input logic [0:127] s);
        logic [0:127] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(4*c+r) +: 8] = s[8*(4*((c - r + 4) % 4) + r) +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [0:127] inv_mix_columns(input logic [0:127] s);
        logic [0:127] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[8*(4*c)   +: 8];
            a1 = s[8*(4*c+1) +: 8];
            a2 = s[8*(4*c+2) +: 8];
            a3 = s[8*(4*c+3) +: 8];
            o[8*(4*c)   +: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[8*(4*c+1) +: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[8*(4*c+2) +: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[8*(4*c+3) +: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

    assign bus.in_ready  = (st_q == IDLE);
    assign bus.out_valid = (st_q == DONE);
    assign bus.busy      = (st_q == SHIFT) || (st_q == SUB) || (st_q == KEY);
    assign bus.out_data  = out_q;
    // IDLE pre-fetches the last round key for the initial whitening XOR.
    assign bus.rk_idx    = (st_q == IDLE) ? 4'(NR) :
                           (st_q == DONE) ? 4'd0   : r_q;

    assign t = blk_q ^ bus.rk_data;

    always_comb begin
        st_d  = st_q;
        blk_d = blk_q;
        out_d = out_q;
        r_d   = r_q;
        k_d   = k_q;
        case (st_q)
            IDLE: begin
                if (bus.in_valid) begin
                    blk_d = bus.in_data ^ bus.rk_data;
                    r_d   = 4'(NR - 1);
                    st_d  = SHIFT;
                end
            end
            SHIFT: begin
                blk_d = inv_shift_rows(blk_q);
                k_d   = '0;
                st_d  = SUB;
            end
            SUB: begin
                // Only SB_LANES S-boxes exist; k selects which byte group they serve this cycle.
                for (int j = 0; j < SB_LANES; j++) begin
                    blk_d[8*(int'(k_q)*SB_LANES + j) +: 8] =
                        inv_sbox(blk_q[8*(int'(k_q)*SB_LANES + j) +: 8]);
                end
                if (k_q == K_LAST) begin
                    k_d  = '0;
                    st_d = KEY;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            KEY: begin
                if (r_q != 4'd0) begin
                    blk_d = inv_mix_columns(t);
                    r_d   = r_q - 4'd1;
                    st_d  = SHIFT;
                end else begin
                    blk_d = t;
                    out_d = t;
                    st_d  = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) st_d = IDLE;
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q  <= IDLE;
            blk_q <= '0;
            out_q <= '0;
            r_q   <= '0;
            k_q   <= '0;
        end else begin
            st_q  <= st_d;
            blk_q <= blk_d;
            out_q <= out_d;
            r_q   <= r_d;
            k_q   <= k_d;
        end
    end

endmodule

// File: tb/tb_inv_cipher_iter.sv
// Bench for inv_cipher_iter: five engines (NR=10 with 16/1/4/8 lanes, NR=14 with 16 lanes).
// Reference: forward AES cipher and key expansion computed here; plaintext is the expected output.
// Key stores are array lookups on each engine's rk_idx.
module tb_inv_cipher_iter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]   sbox [256];
    logic [0:127] rk128 [16];
    logic [0:127] rk256 [16];

    logic         vin  [5];
    logic [0:127] vdat [5];
    logic         vrdy [5];
    logic         ir   [5];
    logic         ov   [5];
    logic         bz   [5];
    logic [0:127] od   [5];
    logic [3:0]   ri   [5];

    localparam logic [0:127] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [0:127] FIPS_PT = 128'h00112233445566778899aabbccddeeff;

    genvar g;
    generate
        for (g = 0; g < 5; g++) begin : g_dut
            localparam int NRG = (g == 4) ? 14 : 10;
            localparam int LNG = (g == 1) ? 1 : (g == 2) ? 4 : (g == 3) ? 8 : 16;
            inv_cipher_iter_if bus_if ();
            assign bus_if.in_valid  = vin[g];
            assign bus_if.in_data   = vdat[g];
            assign bus_if.out_ready = vrdy[g];
            assign bus_if.rk_data   = (NRG == 14) ? rk256[bus_if.rk_idx] : rk128[bus_if.rk_idx];
            assign ir[g] = bus_if.in_ready;
            assign ov[g] = bus_if.out_valid;
            assign bz[g] = bus_if.busy;
            assign od[g] = bus_if.out_data;
            assign ri[g] = bus_if.rk_idx;
            inv_cipher_iter #(.NR(NRG), .SB_LANES(LNG)) u_dut (
                .clk (clk),
                .rst (rst),
                .bus (bus_if)
            );
        end
    endgenerate

    function automatic int nr_of(input int d);
        return (d == 4) ? 14 : 10;
    endfunction

    function automatic int lat_of(input int d);
        int lanes;
        lanes = (d == 1) ? 1 : (d == 2) ? 4 : (d == 3) ? 8 : 16;
        return nr_of(d) * (16 / lanes + 2);
    endfunction

    // ---------------- reference AES (forward direction) ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] v);
        return {sbox[v[31:24]], sbox[v[23:16]], sbox[v[15:8]], sbox[v[7:0]]};
    endfunction

    task automatic expand(input logic [0:255] key, input int nk, input int nr);
        logic [31:0] w [60];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = subw(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int j = 0; j <= nr; j++) begin
            if (nr == 14) rk256[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
            else          rk128[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
        end
    endtask

    function automatic logic [0:127] encrypt(input logic [0:127] pt, input int nr);
        logic [0:127] s;
        logic [0:127] o;
        logic [7:0]   a0, a1, a2, a3;
        s = pt ^ ((nr == 14) ? rk256[0] : rk128[0]);
        for (int rnd = 1; rnd <= nr; rnd++) begin
            for (int i = 0; i < 16; i++) s[8*i +: 8] = sbox[s[8*i +: 8]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    o[8*(4*c+r) +: 8] = s[8*(4*((c + r) % 4) + r) +: 8];
            s = o;
            if (rnd < nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[32*c +: 8]; a1 = s[32*c+8 +: 8]; a2 = s[32*c+16 +: 8]; a3 = s[32*c+24 +: 8];
                    o[32*c    +: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    o[32*c+8  +: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    o[32*c+16 +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    o[32*c+24 +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
                s = o;
            end
            s = s ^ ((nr == 14) ? rk256[rnd] : rk128[rnd]);
        end
        return s;
    endfunction

    task automatic load_fips_keys();
        expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
        expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
    endtask

    function automatic logic [0:127] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One transaction on engine d with out_ready held high; checks latency, data and release.
    task automatic do_block(input int d, input logic [0:127] ct, input logic [0:127] pt, input string nm);
        int n;
        @(negedge clk);
        checks++;
        if (ir[d] !== 1'b1) begin errors++; $display("FAIL %s in_ready before accept: got %b want 1", nm, ir[d]); end
        vin[d] = 1'b1; vdat[d] = ct; vrdy[d] = 1'b1;
        @(posedge clk); @(negedge clk);
        vin[d] = 1'b0; vdat[d] = rand128();
        n = 0;
        while (ov[d] !== 1'b1 && n < 400) begin
            @(posedge clk); n++; @(negedge clk);
        end
        checks++;
        if (n !== lat_of(d)) begin errors++; $display("FAIL %s latency: got %0d want %0d", nm, n, lat_of(d)); end
        checks++;
        if (od[d] !== pt) begin errors++; $display("FAIL %s out_data: got %h want %h", nm, od[d], pt); end
        @(posedge clk); @(negedge clk);
        checks++;
        if (ov[d] !== 1'b0 || ir[d] !== 1'b1) begin
            errors++; $display("FAIL %s release: out_valid=%b in_ready=%b want 0/1", nm, ov[d], ir[d]);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int d = 0; d < 5; d++) begin
            checks++;
            if (ir[d] !== 1'b1 || ov[d] !== 1'b0 || bz[d] !== 1'b0) begin
                errors++; $display("FAIL reset_flags[%0d]: in_ready=%b out_valid=%b busy=%b want 1/0/0", d, ir[d], ov[d], bz[d]);
            end
            checks++;
            if (od[d] !== 128'h0) begin errors++; $display("FAIL reset_out_data[%0d]: got %h want 0", d, od[d]); end
            checks++;
            if (ri[d] !== 4'(nr_of(d))) begin errors++; $display("FAIL reset_rk_idx[%0d]: got %0d want %0d", d, ri[d], nr_of(d)); end
        end
        rst = 1'b0;
    endtask

    task automatic test_fips();
        load_fips_keys();
        do_block(0, C1_CT, FIPS_PT, "fips128_lanes16");
        do_block(1, C1_CT, FIPS_PT, "fips128_lanes1");
        do_block(2, C1_CT, FIPS_PT, "fips128_lanes4");
        do_block(3, C1_CT, FIPS_PT, "fips128_lanes8");
        do_block(4, C3_CT, FIPS_PT, "fips256_lanes16");
    endtask

    task automatic test_random();
        logic [0:127] pt;
        for (int t = 0; t < 4; t++) begin
            expand({rand128(), 128'h0}, 4, 10);
            pt = rand128();
            do_block(0, encrypt(pt, 10), pt, "rand128_lanes16");
            do_block(t % 4, encrypt(pt, 10), pt, "rand128_lanesvar");
        end
        for (int t = 0; t < 2; t++) begin
            expand({rand128(), rand128()}, 8, 14);
            pt = rand128();
            do_block(4, encrypt(pt, 14), pt, "rand256");
        end
        load_fips_keys();
    endtask

    task automatic test_back_to_back();
        int done_cyc [$];
        int guard;
        @(negedge clk);
        vin[0] = 1'b1; vdat[0] = C1_CT; vrdy[0] = 1'b1;
        guard = 0;
        while (done_cyc.size() < 3 && guard < 300) begin
            @(negedge clk); guard++;
            if (ov[0] === 1'b1) begin
                done_cyc.push_back(cyc);
                checks++;
                if (od[0] !== FIPS_PT) begin errors++; $display("FAIL b2b_data: got %h want %h", od[0], FIPS_PT); end
            end
        end
        vin[0] = 1'b0;
        checks++;
        if (done_cyc.size() != 3) begin
            errors++; $display("FAIL b2b_count: got %0d results want 3", done_cyc.size());
        end else begin
            checks++;
            if (done_cyc[1] - done_cyc[0] != 32 || done_cyc[2] - done_cyc[1] != 32) begin
                errors++; $display("FAIL b2b_period: got %0d,%0d want 32", done_cyc[1] - done_cyc[0], done_cyc[2] - done_cyc[1]);
            end
        end
        repeat (40) @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [0:127] pt2;
        int n;
        pt2 = rand128();
        @(negedge clk);
        vin[0] = 1'b1; vdat[0] = C1_CT; vrdy[0] = 1'b0;
        @(posedge clk); @(negedge clk);
        vin[0] = 1'b0;
        n = 0;
        while (ov[0] !== 1'b1 && n < 400) begin @(posedge clk); n++; @(negedge clk); end
        checks++;
        if (n !== 30) begin errors++; $display("FAIL bp_latency: got %0d want 30", n); end
        vin[0] = 1'b1; vdat[0] = encrypt(pt2, 10);
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || od[0] !== FIPS_PT) begin
                errors++; $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b out_data=%h want 1/0/%h", i, ov[0], ir[0], od[0], FIPS_PT);
            end
            @(posedge clk); @(negedge clk);
        end
        vrdy[0] = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if (ir[0] !== 1'b1 || ov[0] !== 1'b0 || od[0] !== FIPS_PT) begin
            errors++; $display("FAIL bp_idle: in_ready=%b out_valid=%b out_data=%h want 1/0/%h", ir[0], ov[0], od[0], FIPS_PT);
        end
        @(posedge clk); @(negedge clk);
        vin[0] = 1'b0;
        checks++;
        if (bz[0] !== 1'b1) begin errors++; $display("FAIL bp_second_accept: busy=%b want 1", bz[0]); end
        n = 0;
        while (ov[0] !== 1'b1 && n < 400) begin @(posedge clk); n++; @(negedge clk); end
        checks++;
        if (n !== 30 || od[0] !== pt2) begin
            errors++; $display("FAIL bp_second_block: latency %0d data %h want 30 %h", n, od[0], pt2);
        end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        vin[0] = 1'b1; vdat[0] = C1_CT; vrdy[0] = 1'b1;
        @(posedge clk); @(negedge clk);
        vin[0] = 1'b0;
        repeat (17) begin @(posedge clk); @(negedge clk); end
        checks++;
        if (bz[0] !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b want 1", bz[0]); end
        rst = 1'b1;
        #1;
        checks++;
        if (ir[0] !== 1'b1 || ov[0] !== 1'b0 || bz[0] !== 1'b0 || od[0] !== 128'h0 || ri[0] !== 4'd10) begin
            errors++; $display("FAIL rstmid_values: in_ready=%b out_valid=%b busy=%b out_data=%h rk_idx=%0d want 1/0/0/0/10",
                               ir[0], ov[0], bz[0], od[0], ri[0]);
        end
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin @(posedge clk); @(negedge clk); if (ov[0] === 1'b1) seen++; end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL rstmid_no_pulse: got %0d out_valid cycles want 0", seen); end
        do_block(0, C1_CT, FIPS_PT, "rstmid_reissue");
    endtask

    task automatic test_rk_trace();
        int exp_q [$];
        int obs_q [$];
        exp_q.push_back(10);
        for (int r = 9; r >= 0; r--) repeat (3) exp_q.push_back(r);
        exp_q.push_back(0);
        @(negedge clk);
        vin[0] = 1'b1; vdat[0] = C1_CT; vrdy[0] = 1'b1;
        obs_q.push_back(int'(ri[0]));
        @(posedge clk); @(negedge clk);
        vin[0] = 1'b0;
        for (int i = 0; i <= 30; i++) begin
            obs_q.push_back(int'(ri[0]));
            if (i < 30) begin @(posedge clk); @(negedge clk); end
        end
        checks++;
        if (ov[0] !== 1'b1) begin errors++; $display("FAIL rk_trace_done: out_valid=%b want 1", ov[0]); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] != exp_q[i]) begin
                errors++; $display("FAIL rk_trace[%0d]: got %0d want %0d", i, obs_q[i], exp_q[i]);
            end
        end
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 5; d++) begin
            vin[d] = 1'b0; vdat[d] = '0; vrdy[d] = 1'b1;
        end
        build_sbox();
        load_fips_keys();
        test_reset();
        test_fips();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_rk_trace();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
